ps2_transmitter: RTL and testbench
==================================

# ps2_transmitter

Host-to-device PS/2 transmitter. It sends one command byte, such as keyboard LED set 8'hED or reset 8'hFF, over the same open-drain PS2_clock/PS2_data pair that the PS/2 receive path listens on. It performs the clock inhibit and request-to-send sequence, then shifts out the start bit, 8 data bits LSB first, odd parity and the stop bit on device-generated clock edges. It finishes by checking the device acknowledge bit.

## Interface
- INHIBIT_CYCLES, default 5000: Clock_50 cycles the host holds PS2_clock low (100 us at 50 MHz).
- TIMEOUT_CYCLES, default 750000: maximum Clock_50 cycles allowed from clock release to the acknowledge bit (15 ms).
- Clock_50  input  1  system clock; the only clock.
- Resetn  input  1  asynchronous, active-low reset.
- PS2_clock  input  1  raw PS/2 clock line level.
- PS2_data  input  1  raw PS/2 data line level.
- TX_data  input  8  byte to send; sampled on the accepting cycle.
- TX_start  input  1  request strobe; accepted only when TX_busy=0.
- TX_busy  output  1  high from the cycle after acceptance until completion.
- TX_done  output  1  one-cycle pulse at completion (success or error).
- TX_error  output  1  valid with TX_done; 1 = timeout or missing acknowledge; held until next acceptance.
- PS2_clock_drive_low  output  1  1 = pull PS2_clock low (top level drives 1'b0 or 1'bz).
- PS2_data_drive_low  output  1  1 = pull PS2_data low.

## Operation
- Both lines pass through a 2-FF synchronizer. fall = ~clock_sync & clock_buf. All shifting uses fall.
- States: S_TX_IDLE, S_TX_INHIBIT, S_TX_REQUEST, S_TX_DATA, S_TX_PARITY, S_TX_STOP, S_TX_ACK.
- S_TX_IDLE: when TX_start=1, do all of the following, then go to S_TX_INHIBIT:
  - latch TX_data into the shift register;
  - set parity = ~^TX_data;
  - clear TX_error;
  - set PS2_clock_drive_low=1;
  - clear the cycle counter.
- S_TX_INHIBIT: count up. When count = INHIBIT_CYCLES-1, set PS2_data_drive_low=1 (the start bit) and go to S_TX_REQUEST.
- S_TX_REQUEST: stay one cycle. Set PS2_clock_drive_low=0, bit_count=0, clear the counter, go to S_TX_DATA.
- S_TX_DATA: on each fall, set PS2_data_drive_low <= ~shift[0] and shift right. After the 8th fall (bit_count=7), go to S_TX_PARITY.
- S_TX_PARITY: on fall, set PS2_data_drive_low <= ~parity and go to S_TX_STOP.
- S_TX_STOP: on fall, set PS2_data_drive_low <= 0 (release, stop bit = 1) and go to S_TX_ACK.
- S_TX_ACK: on fall, set TX_error <= data_sync (1 = no acknowledge), pulse TX_done, and go to S_TX_IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in any state from S_TX_DATA through S_TX_ACK:
  - release both lines;
  - set TX_error=1 and pulse TX_done;
  - go to S_TX_IDLE.
- Receiver output is invalid while TX_busy=1; the consumer ignores PS2_code_ready during this window.

## Timing
- Reset values: TX_busy=0, TX_done=0, TX_error=0, both drive_low outputs 0, state S_TX_IDLE, shift register 8'd0, counters 0.
- TX_start has a 1-cycle accept latency, so TX_busy rises the following cycle.
- TX_start while busy is ignored, not queued.
- TX_start in the same cycle as TX_done is ignored; a new request is accepted no earlier than the cycle after TX_done.
- Counter is 20 bits wide and saturates; it is cleared at each state entry except that S_TX_DATA through S_TX_ACK share one count.
- Reset mid-frame: both lines are released immediately (asynchronous) and no TX_done pulse is issued.
- A data bit changes 3 cycles after the raw falling edge of PS2_clock (2 synchronizer cycles plus 1 register stage).

## Configuration
- PS2_TX_ACK_CHECK_EN defined: behaviour as above; S_TX_ACK samples the acknowledge bit and sets TX_error from it.
- PS2_TX_ACK_CHECK_EN undefined:
  - S_TX_ACK is removed;
  - the S_TX_STOP fall ends the frame, pulses TX_done and returns to S_TX_IDLE;
  - TX_error can be set only by timeout.

## Structure
- Shared package ps2_pkg holds:
  - the tx state enum;
  - command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4;
  - the default cycle constants.
- Sub-module ps2_line_sync: 2-FF synchronizer for both lines plus the fall detector. The receive path reuses it.

## Test plan
- Send 8'hED with a bench device model (clock period 80 us, ACK low):
  - PS2_clock_drive_low high for exactly 5000 cycles, then start bit;
  - PS2_data_drive_low sequence on falls: 0,1,0,0,1,0,0,0;
  - parity 0, stop 0;
  - TX_done pulse with TX_error=0.
- Send 8'h00: all data-bit drive_low values 1, parity drive_low 0 (parity bit 1), TX_error=0.
- Send 8'h07: parity drive_low 1 (parity bit 0); verify bits 1,1,1,0,0,0,0,0 on the wire.
- Device never clocks after release: TX_done at 750000 cycles, TX_error=1, both drive_low outputs 0.
- Device leaves data high at the ACK bit:
  - with PS2_TX_ACK_CHECK_EN, TX_error=1;
  - without it, TX_done one edge earlier with TX_error=0.
- Resetn asserted during bit 4 of 8'hFF: both drive_low outputs 0 at once, TX_busy=0, no TX_done. A subsequent TX_start=1 with 8'hF4 completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, host command bytes and default cycle budgets.
package ps2_pkg;

   localparam int PS2_CNT_W          = 20;
   localparam int PS2_INHIBIT_CYCLES = 5000;    // 100 us at 50 MHz
   localparam int PS2_TIMEOUT_CYCLES = 750000;  // 15 ms at 50 MHz

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

   typedef logic [2:0] ps2_tx_state_t;

   localparam ps2_tx_state_t S_TX_IDLE    = 3'd0;
   localparam ps2_tx_state_t S_TX_INHIBIT = 3'd1;
   localparam ps2_tx_state_t S_TX_REQUEST = 3'd2;
   localparam ps2_tx_state_t S_TX_DATA    = 3'd3;
   localparam ps2_tx_state_t S_TX_PARITY  = 3'd4;
   localparam ps2_tx_state_t S_TX_STOP    = 3'd5;
   localparam ps2_tx_state_t S_TX_ACK     = 3'd6;

   function automatic logic ps2_odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a clock falling-edge strobe.
// Shared by the transmit and receive paths; lines reset to their idle-high level so no false edge appears.
module ps2_line_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic ps2_clock_i,
   input  logic ps2_data_i,
   output logic data_sync_o,
   output logic fall_o
);

   logic clock_meta_q, clock_sync_q, clock_buf_q;
   logic data_meta_q, data_sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clock_meta_q <= 1'b1;
         clock_sync_q <= 1'b1;
         clock_buf_q  <= 1'b1;
         data_meta_q  <= 1'b1;
         data_sync_q  <= 1'b1;
      end else begin
         clock_meta_q <= ps2_clock_i;
         clock_sync_q <= clock_meta_q;
         clock_buf_q  <= clock_sync_q;
         data_meta_q  <= ps2_data_i;
         data_sync_q  <= data_meta_q;
      end
   end

   assign data_sync_o = data_sync_q;
   assign fall_o      = ~clock_sync_q & clock_buf_q;

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send, then 11-bit frame on device clock falls.
// Define PS2_TX_ACK_CHECK_EN to sample the device acknowledge bit after the stop bit.
module ps2_transmitter
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
   input  logic       Clock_50,
   input  logic       Resetn,
   input  logic       PS2_clock,
   input  logic       PS2_data,
   input  logic [7:0] TX_data,
   input  logic       TX_start,
   output logic       TX_busy,
   output logic       TX_done,
   output logic       TX_error,
   output logic       PS2_clock_drive_low,
   output logic       PS2_data_drive_low
);

   localparam logic [PS2_CNT_W-1:0] INH_LAST = PS2_CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [PS2_CNT_W-1:0] TO_LAST  = PS2_CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PS2_CNT_W-1:0] CNT_MAX  = '1;

   ps2_tx_state_t        state_q, state_d;
   logic [7:0]           shift_q, shift_d;
   logic                 parity_q, parity_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [PS2_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 clk_drv_q, clk_drv_d;
   logic                 data_drv_q, data_drv_d;
   logic                 fall, data_sync, timeout;

   ps2_line_sync u_line_sync (
      .clk_i       (Clock_50),
      .rst_ni      (Resetn),
      .ps2_clock_i (PS2_clock),
      .ps2_data_i  (PS2_data),
      .data_sync_o (data_sync),
      .fall_o      (fall)
   );

`ifndef PS2_TX_ACK_CHECK_EN
   logic unused_data_sync;
   assign unused_data_sync = data_sync;
`endif

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   // Registered done is one cycle after the reaching count, so TX_done lands TIMEOUT_CYCLES after clock release.
   assign timeout = (cnt_q >= TO_LAST);

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      bit_cnt_d  = bit_cnt_q;
      cnt_d      = cnt_inc;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      clk_drv_d  = clk_drv_q;
      data_drv_d = data_drv_q;

      case (state_q)
         S_TX_IDLE: begin
            cnt_d = '0;
            // A request landing on the done cycle is dropped so completion and acceptance never overlap.
            if (TX_start && !done_q) begin
               shift_d   = TX_data;
               parity_d  = ps2_odd_parity(TX_data);
               err_d     = 1'b0;
               clk_drv_d = 1'b1;
               busy_d    = 1'b1;
               state_d   = S_TX_INHIBIT;
            end
         end
         S_TX_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               data_drv_d = 1'b1;
               cnt_d      = '0;
               state_d    = S_TX_REQUEST;
            end
         end
         S_TX_REQUEST: begin
            clk_drv_d = 1'b0;
            bit_cnt_d = '0;
            cnt_d     = '0;
            state_d   = S_TX_DATA;
         end
         default: begin
            if (timeout) begin
               clk_drv_d  = 1'b0;
               data_drv_d = 1'b0;
               err_d      = 1'b1;
               done_d     = 1'b1;
               busy_d     = 1'b0;
               state_d    = S_TX_IDLE;
            end else if (fall) begin
               case (state_q)
                  S_TX_DATA: begin
                     data_drv_d = ~shift_q[0];
                     shift_d    = {1'b0, shift_q[7:1]};
                     bit_cnt_d  = bit_cnt_q + 1'b1;
                     if (bit_cnt_q == 3'd7) state_d = S_TX_PARITY;
                  end
                  S_TX_PARITY: begin
                     data_drv_d = ~parity_q;
                     state_d    = S_TX_STOP;
                  end
                  S_TX_STOP: begin
                     data_drv_d = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
                     state_d    = S_TX_ACK;
`else
                     done_d     = 1'b1;
                     busy_d     = 1'b0;
                     state_d    = S_TX_IDLE;
`endif
                  end
`ifdef PS2_TX_ACK_CHECK_EN
                  S_TX_ACK: begin
                     err_d   = data_sync;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = S_TX_IDLE;
                  end
`endif
                  default: begin
                     clk_drv_d  = 1'b0;
                     data_drv_d = 1'b0;
                     busy_d     = 1'b0;
                     state_d    = S_TX_IDLE;
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= S_TX_IDLE;
         shift_q    <= 8'd0;
         parity_q   <= 1'b0;
         bit_cnt_q  <= 3'd0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         clk_drv_q  <= 1'b0;
         data_drv_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         bit_cnt_q  <= bit_cnt_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         clk_drv_q  <= clk_drv_d;
         data_drv_q <= data_drv_d;
      end
   end

   assign TX_busy             = busy_q;
   assign TX_done             = done_q;
   assign TX_error            = err_q;
   assign PS2_clock_drive_low = clk_drv_q;
   assign PS2_data_drive_low  = data_drv_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: open-drain device model clocks frames in, reference model derives the expected wire bits.
module tb_ps2_transmitter;

   localparam int INH = 40;
   localparam int TO  = 1500;
   localparam int H   = 20;
`ifdef PS2_TX_ACK_CHECK_EN
   localparam int NFALL  = 11;
   localparam bit ACK_EN = 1'b1;
`else
   localparam int NFALL  = 10;
   localparam bit ACK_EN = 1'b0;
`endif

   logic       Clock_50 = 1'b0;
   logic       Resetn   = 1'b0;
   logic       dev_clk  = 1'b1;
   logic       dev_data = 1'b1;
   logic       TX_start = 1'b0;
   logic [7:0] TX_data  = 8'd0;
   logic       TX_busy, TX_done, TX_error;
   logic       PS2_clock_drive_low, PS2_data_drive_low;
   logic       PS2_clock, PS2_data;

   assign PS2_clock = dev_clk & ~PS2_clock_drive_low;
   assign PS2_data  = dev_data & ~PS2_data_drive_low;

   ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .Clock_50            (Clock_50),
      .Resetn              (Resetn),
      .PS2_clock           (PS2_clock),
      .PS2_data            (PS2_data),
      .TX_data             (TX_data),
      .TX_start            (TX_start),
      .TX_busy             (TX_busy),
      .TX_done             (TX_done),
      .TX_error            (TX_error),
      .PS2_clock_drive_low (PS2_clock_drive_low),
      .PS2_data_drive_low  (PS2_data_drive_low)
   );

   always #5 Clock_50 = ~Clock_50;

   int   tests_run    = 0;
   int   tests_failed = 0;
   int   done_cnt     = 0;
   logic done_err     = 1'bx;
   bit   arm_on_done  = 1'b0;
   bit   clr_start    = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Line drive expected after device fall k: data bits LSB first, odd parity, then released.
   function automatic logic exp_drive(input logic [7:0] b, input int k);
      int ones = 0;
      if (k < 8) return ((b >> k) & 8'd1) == 8'd0;
      if (k == 8) begin
         for (int i = 0; i < 8; i++) ones += int'((b >> i) & 8'd1);
         return (ones % 2) == 1;
      end
      return 1'b0;
   endfunction

   task automatic tick();
      @(negedge Clock_50);
      if (clr_start) begin
         TX_start  = 1'b0;
         clr_start = 1'b0;
      end
      if (TX_done === 1'b1) begin
         done_cnt++;
         done_err = TX_error;
         if (arm_on_done) begin
            TX_data     = 8'hAA;
            TX_start    = 1'b1;
            clr_start   = 1'b1;
            arm_on_done = 1'b0;
         end
      end
   endtask

   task automatic start_tx(input logic [7:0] b);
      chk("busy_before_start", TX_busy, 0);
      TX_data  = b;
      TX_start = 1'b1;
      done_cnt = 0;
      done_err = 1'bx;
      tick();
      TX_start = 1'b0;
      TX_data  = ~b;
      chk("busy_after_accept", TX_busy, 1);
      chk("clk_inhibit_on", PS2_clock_drive_low, 1);
      chk("err_cleared_on_accept", TX_error, 0);
   endtask

   task automatic inhibit_phase();
      int n = 1;
      int guard = 0;
      while (PS2_data_drive_low !== 1'b1 && guard < 4 * INH) begin
         tick();
         guard++;
         if (PS2_data_drive_low !== 1'b1 && PS2_clock_drive_low === 1'b1) n++;
      end
      chk("inhibit_len", n, INH);
      chk("request_clk_held", PS2_clock_drive_low, 1);
      tick();
      chk("clk_released", PS2_clock_drive_low, 0);
      chk("start_bit_drive", PS2_data_drive_low, 1);
   endtask

   task automatic device_frame(input logic [7:0] b, input bit ack_low, input bit poke, input int abort_at);
      logic exp_err;
      exp_err = ACK_EN & ~ack_low;
      repeat (H) tick();
      for (int k = 0; k < NFALL; k++) begin
         if (k == NFALL - 1) chk("no_early_done", done_cnt, 0);
         if (k == 10) begin
            dev_data = ack_low ? 1'b0 : 1'b1;
            repeat (4) tick();
         end
         dev_clk = 1'b0;
         tick();
         tick();
         chk("pre_edge_hold", PS2_data_drive_low, (k == 0) ? 1'b1 : exp_drive(b, k - 1));
         tick();
         chk("bit_drive", PS2_data_drive_low, exp_drive(b, k));
         if (k == abort_at) begin
            dev_clk = 1'b1;
            Resetn  = 1'b0;
            #1;
            chk("rst_clk_release", PS2_clock_drive_low, 0);
            chk("rst_data_release", PS2_data_drive_low, 0);
            chk("rst_busy", TX_busy, 0);
            repeat (3) tick();
            Resetn = 1'b1;
            repeat (5) tick();
            chk("rst_no_done", done_cnt, 0);
            return;
         end
         repeat (H - 3) tick();
         dev_clk = 1'b1;
         if (poke && k == 4) begin
            TX_data  = 8'h00;
            TX_start = 1'b1;
            tick();
            TX_start = 1'b0;
            repeat (H - 1) tick();
         end else begin
            repeat (H) tick();
         end
      end
      dev_data = 1'b1;
      repeat (4) tick();
      chk("done_pulses", done_cnt, 1);
      chk("done_error", done_err, exp_err);
      chk("busy_after_done", TX_busy, 0);
      chk("clk_drive_idle", PS2_clock_drive_low, 0);
      chk("data_drive_idle", PS2_data_drive_low, 0);
   endtask

   initial begin
      logic [7:0] rb;
      bit         rack;
      int         cyc;

      #1;
      chk("reset_busy", TX_busy, 0);
      chk("reset_done", TX_done, 0);
      chk("reset_error", TX_error, 0);
      chk("reset_clk_drive", PS2_clock_drive_low, 0);
      chk("reset_data_drive", PS2_data_drive_low, 0);
      repeat (3) tick();
      Resetn = 1'b1;
      repeat (3) tick();

      // Set-LED command with a request poked mid-frame that must be neither accepted nor queued.
      start_tx(8'hED);
      inhibit_phase();
      device_frame(8'hED, 1'b1, 1'b1, -1);
      repeat (10) tick();
      chk("busy_request_not_queued", TX_busy, 0);

      // All-zero byte; a request on the done cycle itself must be dropped.
      start_tx(8'h00);
      inhibit_phase();
      arm_on_done = 1'b1;
      device_frame(8'h00, 1'b1, 1'b0, -1);
      repeat (5) tick();
      chk("start_on_done_ignored", TX_busy, 0);
      arm_on_done = 1'b0;

      start_tx(8'h07);
      inhibit_phase();
      device_frame(8'h07, 1'b1, 1'b0, -1);

      // Device leaves data high at the acknowledge slot.
      start_tx(8'h5A);
      inhibit_phase();
      device_frame(8'h5A, 1'b0, 1'b0, -1);

      // Device never clocks after the host releases the clock.
      start_tx(PS2_CMD_ENABLE_TB());
      inhibit_phase();
      cyc = 0;
      while (TX_done !== 1'b1 && cyc < TO + 100) begin
         tick();
         cyc++;
      end
      chk("timeout_len", cyc, TO);
      chk("timeout_error", TX_error, 1);
      chk("timeout_clk_release", PS2_clock_drive_low, 0);
      chk("timeout_data_release", PS2_data_drive_low, 0);
      repeat (20) tick();
      chk("timeout_error_held", TX_error, 1);
      chk("timeout_done_pulses", done_cnt, 1);

      // Reset during bit 4 of the reset command, then a normal enable command.
      start_tx(8'hFF);
      inhibit_phase();
      device_frame(8'hFF, 1'b1, 1'b0, 4);
      start_tx(8'hF4);
      inhibit_phase();
      device_frame(8'hF4, 1'b1, 1'b0, -1);

      // Reset during the clock inhibit window.
      start_tx(8'h3C);
      repeat (10) tick();
      Resetn = 1'b0;
      #1;
      chk("rst_inhibit_clk_release", PS2_clock_drive_low, 0);
      chk("rst_inhibit_busy", TX_busy, 0);
      tick();
      Resetn = 1'b1;
      repeat (3) tick();
      chk("rst_inhibit_no_done", done_cnt, 0);

      for (int i = 0; i < 4; i++) begin
         rb   = 8'($urandom);
         rack = 1'($urandom % 2);
         start_tx(rb);
         inhibit_phase();
         device_frame(rb, rack, 1'b0, -1);
         repeat ($urandom_range(1, 8)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   function automatic logic [7:0] PS2_CMD_ENABLE_TB();
      return 8'hF4;
   endfunction

endmodule
